pb_event_scheduler: RTL and testbench

- Sits between a bank of push-button debouncer instances and the microcontroller's input/event path.
- Tracks each button's hold duration from the debouncers' one-cycle pressed/released pulses.
- Classifies each hold into SHORT, LONG or REPEAT events.
- Arbitrates the per-button events round-robin onto one valid/ready event channel consumed by the core.

---
 rtl/pb_event_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_pb_event_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_event_scheduler.sv
// rtl/pb_event_scheduler.sv - per-button hold classifier with round-robin event output
module pb_event_scheduler #(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int IDX_W         = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pressed_pulse,
    input  logic [N_BTN-1:0] released_pulse,
    input  logic [N_BTN-1:0] btn_enable,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [IDX_W-1:0] ev_btn,
    output logic [1:0]       ev_code,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int MAX_CYC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] CODE_SHORT  = 2'b00;
    localparam logic [1:0] CODE_LONG   = 2'b01;
    localparam logic [1:0] CODE_REPEAT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG_HELD
    } state_t;

    state_t             state_q      [N_BTN];
    state_t             state_d      [N_BTN];
    logic [TMR_W-1:0]   timer_q      [N_BTN];
    logic [TMR_W-1:0]   timer_d      [N_BTN];
    logic [N_BTN-1:0]   slot_valid_q;
    logic [N_BTN-1:0]   slot_valid_d;
    logic [1:0]         slot_code_q  [N_BTN];
    logic [1:0]         slot_code_d  [N_BTN];
    logic               ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0]   ev_btn_q, ev_btn_d;
    logic [1:0]         ev_code_q, ev_code_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               overflow_q, overflow_d;

    logic               load;
    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand_idx;
    logic               post;
    logic [1:0]         post_code;
    logic               drop;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        slot_valid_d = slot_valid_q;
        slot_code_d  = slot_code_q;
        ev_valid_d   = ev_valid_q;
        ev_btn_d     = ev_btn_q;
        ev_code_d    = ev_code_q;
        ptr_d        = ptr_q;
        overflow_d   = overflow_q;
        grant_found  = 1'b0;
        grant_idx    = '0;
        cand_idx     = '0;
        post         = 1'b0;
        post_code    = CODE_SHORT;
        drop         = 1'b0;

        load = !ev_valid_q || ev_ready;

        // Scan starts just past the last winner so every channel gets a turn.
        for (int k = 1; k <= N_BTN; k++) begin
            cand_idx = IDX_W'((int'(ptr_q) + k) % N_BTN);
            if (!grant_found && slot_valid_q[cand_idx] && btn_enable[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end

        if (load) begin
            ev_valid_d = grant_found;
            if (grant_found) begin
                ev_btn_d                = grant_idx;
                ev_code_d               = slot_code_q[grant_idx];
                ptr_d                   = grant_idx;
                slot_valid_d[grant_idx] = 1'b0;
            end
        end

        for (int i = 0; i < N_BTN; i++) begin
            post      = 1'b0;
            post_code = CODE_SHORT;
            if (!btn_enable[i]) begin
                state_d[i]      = ST_IDLE;
                timer_d[i]      = '0;
                slot_valid_d[i] = 1'b0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (pressed_pulse[i]) begin
                            state_d[i] = ST_HELD;
                            timer_d[i] = '0;
                        end
                    end
                    ST_HELD: begin
                        timer_d[i] = timer_q[i] + 1'b1;
                        if (released_pulse[i]) begin
                            post       = 1'b1;
                            post_code  = CODE_SHORT;
                            state_d[i] = ST_IDLE;
                            timer_d[i] = '0;
                        end else if (timer_q[i] == LONG_LAST) begin
                            post       = 1'b1;
                            post_code  = CODE_LONG;
                            state_d[i] = ST_LONG_HELD;
                            timer_d[i] = '0;
                        end
                    end
                    ST_LONG_HELD: begin
                        timer_d[i] = timer_q[i] + 1'b1;
                        if (released_pulse[i]) begin
                            state_d[i] = ST_IDLE;
                            timer_d[i] = '0;
                        end else if (timer_q[i] == REP_LAST) begin
                            post       = 1'b1;
                            post_code  = CODE_REPEAT;
                            timer_d[i] = '0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        timer_d[i] = '0;
                    end
                endcase

                // slot_valid_d already reflects this cycle's grant, so a freed slot accepts the post.
                if (post) begin
                    if (slot_valid_d[i]) begin
                        drop = 1'b1;
                    end else begin
                        slot_valid_d[i] = 1'b1;
                        slot_code_d[i]  = post_code;
                    end
                end
            end
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]     <= ST_IDLE;
                timer_q[i]     <= '0;
                slot_code_q[i] <= CODE_SHORT;
            end
            slot_valid_q <= '0;
            ev_valid_q   <= 1'b0;
            ev_btn_q     <= '0;
            ev_code_q    <= CODE_SHORT;
            ptr_q        <= IDX_W'(N_BTN - 1);
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            slot_code_q  <= slot_code_d;
            slot_valid_q <= slot_valid_d;
            ev_valid_q   <= ev_valid_d;
            ev_btn_q     <= ev_btn_d;
            ev_code_q    <= ev_code_d;
            ptr_q        <= ptr_d;
            overflow_q   <= overflow_d;
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_btn   = ev_btn_q;
    assign ev_code  = ev_code_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pb_event_scheduler.sv
// tb/tb_pb_event_scheduler.sv - directed scenarios and random traffic against a hold-time model
module tb_pb_event_scheduler;

    localparam int N    = 4;
    localparam int LONG = 8;
    localparam int REP  = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] pressed_pulse;
    logic [N-1:0] released_pulse;
    logic [N-1:0] btn_enable;
    logic         ev_valid;
    logic         ev_ready;
    logic [1:0]   ev_btn;
    logic [1:0]   ev_code;
    logic         overflow;
    logic         clr_overflow;

    pb_event_scheduler #(
        .N_BTN(N),
        .LONG_CYCLES(LONG),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pressed_pulse(pressed_pulse),
        .released_pulse(released_pulse),
        .btn_enable(btn_enable),
        .ev_valid(ev_valid),
        .ev_ready(ev_ready),
        .ev_btn(ev_btn),
        .ev_code(ev_code),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: a held button is described only by the cycle it was pressed.
    bit m_held    [N];
    int m_press   [N];
    bit m_slot_v  [N];
    int m_slot_c  [N];
    bit m_ev_v;
    int m_ev_btn;
    int m_ev_code;
    int m_ptr;
    bit m_ovf;
    int mcyc = 0;

    int log_q[$];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        bit load;
        int found;
        int c;
        int e;
        int ev;
        bit drop;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_held[i]   = 0;
                m_slot_v[i] = 0;
            end
            m_ev_v    = 0;
            m_ev_btn  = 0;
            m_ev_code = 0;
            m_ptr     = N - 1;
            m_ovf     = 0;
        end else begin
            load = !m_ev_v || ev_ready;
            if (load) begin
                found = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (found < 0 && m_slot_v[c] && btn_enable[c]) found = c;
                end
                if (found >= 0) begin
                    m_ev_v           = 1;
                    m_ev_btn         = found;
                    m_ev_code        = m_slot_c[found];
                    m_slot_v[found]  = 0;
                    m_ptr            = found;
                end else begin
                    m_ev_v = 0;
                end
            end
            drop = 0;
            for (int i = 0; i < N; i++) begin
                if (!btn_enable[i]) begin
                    m_held[i]   = 0;
                    m_slot_v[i] = 0;
                end else if (!m_held[i]) begin
                    if (pressed_pulse[i]) begin
                        m_held[i]  = 1;
                        m_press[i] = mcyc;
                    end
                end else begin
                    e  = mcyc - m_press[i];
                    ev = -1;
                    if (released_pulse[i]) begin
                        if (e <= LONG) ev = 0;
                        m_held[i] = 0;
                    end else if (e == LONG) begin
                        ev = 1;
                    end else if (e > LONG && ((e - LONG) % REP) == 0) begin
                        ev = 2;
                    end
                    if (ev >= 0) begin
                        if (m_slot_v[i]) begin
                            drop = 1;
                        end else begin
                            m_slot_v[i] = 1;
                            m_slot_c[i] = ev;
                        end
                    end
                end
            end
            if (drop) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
        end
        mcyc++;
    endtask

    task automatic tick();
        if (!rst && ev_valid && ev_ready) log_q.push_back(int'(ev_btn) * 4 + int'(ev_code));
        model_step();
        @(posedge clk);
        #1;
        check("ev_valid", int'(ev_valid), int'(m_ev_v));
        check("overflow", int'(overflow), int'(m_ovf));
        if (m_ev_v) begin
            check("ev_btn", int'(ev_btn), m_ev_btn);
            check("ev_code", int'(ev_code), m_ev_code);
        end
    endtask

    task automatic cyc(input logic [N-1:0] pr, input logic [N-1:0] rl);
        pressed_pulse  = pr;
        released_pulse = rl;
        tick();
        pressed_pulse  = '0;
        released_pulse = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, '0);
    endtask

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            check({tag, "_entry"}, log_q[i], exp[i]);
    endtask

    initial begin
        rst            = 1;
        pressed_pulse  = '0;
        released_pulse = '0;
        btn_enable     = '1;
        ev_ready       = 1;
        clr_overflow   = 0;
        idle(2);
        check("rst_valid", int'(ev_valid), 0);
        check("rst_btn", int'(ev_btn), 0);
        check("rst_code", int'(ev_code), 0);
        check("rst_ovf", int'(overflow), 0);
        rst = 0;
        idle(3);

        // Short press on button 1: release 4 cycles after press.
        log_q.delete();
        cyc(4'b0010, '0);
        idle(3);
        cyc('0, 4'b0010);
        idle(1);
        check("short_valid", int'(ev_valid), 1);
        check("short_btn", int'(ev_btn), 1);
        check("short_code", int'(ev_code), 0);
        idle(1);
        check("short_one_cycle", int'(ev_valid), 0);
        idle(5);
        check_log("short", '{4});

        // Long + repeat on button 2, release coincides with a would-be REPEAT.
        log_q.delete();
        cyc(4'b0100, '0);
        idle(19);
        cyc('0, 4'b0100);
        idle(10);
        check_log("long_rep", '{9, 10, 10});

        // Release in the same cycle as the LONG timeout.
        log_q.delete();
        cyc(4'b0001, '0);
        idle(7);
        cyc('0, 4'b0001);
        idle(12);
        check_log("boundary", '{0});

        rst = 1;
        idle(1);
        rst = 0;

        // Fairness: buttons 0, 1, 3 post SHORT together, twice.
        for (int r = 0; r < 2; r++) begin
            log_q.delete();
            cyc(4'b1011, '0);
            idle(1);
            cyc('0, 4'b1011);
            idle(6);
            check_log("fair", '{0, 4, 12});
        end

        // Backpressure: third SHORT on button 2 is dropped.
        log_q.delete();
        ev_ready = 0;
        cyc(4'b0100, '0);
        cyc('0, 4'b0100);
        idle(3);
        cyc(4'b0100, '0);
        cyc('0, 4'b0100);
        idle(2);
        cyc(4'b0100, '0);
        cyc('0, 4'b0100);
        idle(1);
        check("bp_ovf", int'(overflow), 1);
        check("bp_valid", int'(ev_valid), 1);
        check("bp_btn", int'(ev_btn), 2);
        check("bp_code", int'(ev_code), 0);
        idle(3);
        check("bp_btn_stable", int'(ev_btn), 2);
        clr_overflow = 1;
        idle(1);
        clr_overflow = 0;
        check("bp_clr", int'(overflow), 0);
        ev_ready = 1;
        idle(5);
        check_log("bp", '{8, 8});

        // Reset while button 3 is in LONG_HELD with a REPEAT pending.
        log_q.delete();
        ev_ready = 0;
        cyc(4'b1000, '0);
        idle(13);
        check("mid_valid_pre", int'(ev_valid), 1);
        rst = 1;
        idle(1);
        rst = 0;
        check("mid_valid", int'(ev_valid), 0);
        check("mid_ovf", int'(overflow), 0);
        ev_ready = 1;
        idle(20);
        check("mid_no_events", log_q.size(), 0);

        // Random traffic against the model.
        for (int t = 0; t < 4000; t++) begin
            logic [N-1:0] pr;
            logic [N-1:0] rl;
            for (int b = 0; b < N; b++) begin
                pr[b]         = ($urandom_range(0, 9) == 0);
                rl[b]         = ($urandom_range(0, 11) == 0);
                btn_enable[b] = ($urandom_range(0, 59) != 0);
            end
            ev_ready     = ($urandom_range(0, 3) != 0);
            clr_overflow = ($urandom_range(0, 39) == 0);
            rst          = ($urandom_range(0, 799) == 0);
            cyc(pr, rl);
        end
        rst          = 0;
        btn_enable   = '1;
        clr_overflow = 0;
        ev_ready     = 1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
